// File: rtl/two_four_pkg.sv
// Shared constants for the 2/4 step counters: step sizes and step-select encodings.
package two_four_pkg;

  localparam int unsigned STEP_SMALL = 2;
  localparam int unsigned STEP_LARGE = 4;

  localparam logic MODE_STEP2 = 1'b0;
  localparam logic MODE_STEP4 = 1'b1;

  // Maps the step-select input onto the step magnitude (3 bits covers both steps).
  function automatic logic [2:0] step_of(input logic mode);
    logic [2:0] step;
    step = 3'(STEP_SMALL);
    case (mode)
      MODE_STEP2: step = 3'(STEP_SMALL);
      MODE_STEP4: step = 3'(STEP_LARGE);
      default:    step = 3'(STEP_SMALL);
    endcase
    return step;
  endfunction

endpackage

// File: rtl/two_four_down_counter_d_ff_sr.sv
// Single-bit D flip-flop with synchronous active-high reset; powers up at 0 in simulation.
module d_ff_sr (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_r = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) q_r <= 1'b0;
    else     q_r <= d;
  end

  assign q = q_r;

endmodule

// File: rtl/two_four_down_counter.sv
// Down counter stepping by 2 or 4 per enabled edge, with parallel load, hold and a
// registered one-cycle borrow pulse when the count wraps below zero.
module two_four_down_counter
  import two_four_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             z,
  output logic             zero
);

  logic [WIDTH-1:0] step;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_count;
  logic             next_z;

  assign step = WIDTH'(step_of(x));
  // Extra MSB of the widened subtraction is the borrow out of the counter.
  assign diff = {1'b0, count} - {1'b0, step};

  always_comb begin
    next_count = count;
    next_z     = 1'b0;
    if (load) begin
      next_count = load_val;
    end else if (en) begin
      next_count = diff[WIDTH-1:0];
      next_z     = diff[WIDTH];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
    d_ff_sr u_bit (
      .clk (clk),
      .rst (rst),
      .d   (next_count[i]),
      .q   (count[i])
    );
  end

  d_ff_sr u_borrow (
    .clk (clk),
    .rst (rst),
    .d   (next_z),
    .q   (z)
  );

  assign zero = (count == '0);

endmodule
